// File: rtl/exp_uart_pkg.sv
// Shared constants and state types for the CPC expansion-port UART.
package exp_uart_pkg;

    localparam logic [15:0] DATA_ADDR = 16'hFBD0;
    localparam logic [15:0] STAT_ADDR = 16'hFBD1;

    localparam int STAT_RX_AVAIL   = 0;
    localparam int STAT_TX_NFULL   = 1;
    localparam int STAT_OVERRUN    = 2;
    localparam int STAT_FRAME_ERR  = 3;
    localparam int STAT_TX_IDLE    = 4;
    localparam int STAT_RX_IE      = 5;
    localparam int STAT_TX_IE      = 6;
    localparam int STAT_IRQ        = 7;

    localparam int CTRL_RX_IE      = 0;
    localparam int CTRL_TX_IE      = 1;
    localparam int CTRL_FLUSH      = 7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/exp_uart_fifo.sv
// Single-clock byte FIFO, 2^AW deep, with show-ahead head and synchronous flush.
module exp_uart_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop on a full FIFO frees the slot the same-cycle push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/exp_uart_port.sv
// CPC expansion-port UART: Z80 I/O responder at &FBD0/&FBD1 bridging to an 8N1 line with FIFOs.
module exp_uart_port
    import exp_uart_pkg::*;
#(
    parameter int BAUD_DIV = 278,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        m1,
    output logic [7:0]  cpu_din,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);
    localparam int            CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

    logic       sel, is_stat, wr_lvl, rd_lvl, wr_event, rd_done;
    logic       wr_lvl_q, rd_lvl_q, rd_stat_q;
    logic       tx_push, tx_pop, ctrl_wr, flush, rx_pop, stat_clr;
    logic [7:0] tx_head, rx_head, stat;
    logic       tx_full, tx_empty, rx_full, rx_empty, tx_idle, rx_good, rx_bad;
    logic       rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;
    logic       overrun_q, overrun_d, frame_err_q, frame_err_d;

    // Interrupt-acknowledge cycles carry m1 and are never ours.
    assign sel      = iorq & ~m1 & (cpu_addr[15:1] == DATA_ADDR[15:1]);
    assign is_stat  = (cpu_addr[0] == STAT_ADDR[0]);
    assign wr_lvl   = sel & wr;
    assign rd_lvl   = sel & rd;
    assign wr_event = wr_lvl & ~wr_lvl_q;
    assign rd_done  = rd_lvl_q & ~rd_lvl;
    assign tx_push  = wr_event & ~is_stat;
    assign ctrl_wr  = wr_event & is_stat;
    assign flush    = ctrl_wr & cpu_dout[CTRL_FLUSH];
    assign rx_pop   = rd_done & ~rd_stat_q;
    assign stat_clr = rd_done & rd_stat_q;

    exp_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .reset(reset), .flush(flush), .push(tx_push), .pop(tx_pop),
        .din(cpu_dout), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    // ---------------- transmitter ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;

    assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
    assign txd     = txd_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        txd_d      = 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_d = tx_shift_q[0];
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_good    = rxd_sync_q;
                    rx_bad     = ~rxd_sync_q;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rxd_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    exp_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .reset(reset), .flush(flush), .push(rx_good), .pop(rx_pop),
        .din(rx_shift_q), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- control, status, read mux ----------------
    always_comb begin
        rx_ie_d     = rx_ie_q;
        tx_ie_d     = tx_ie_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (ctrl_wr) begin
            rx_ie_d = cpu_dout[CTRL_RX_IE];
            tx_ie_d = cpu_dout[CTRL_TX_IE];
        end
        if (stat_clr) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_good && rx_full && !rx_pop) overrun_d = 1'b1;
        if (rx_bad) frame_err_d = 1'b1;
        // Flush beats a same-cycle completion: the byte is lost without an overrun.
        if (flush) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        irq_d = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_idle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_lvl_q    <= 1'b0;
            rd_lvl_q    <= 1'b0;
            rd_stat_q   <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            wr_lvl_q    <= wr_lvl;
            rd_lvl_q    <= rd_lvl;
            if (rd_lvl) rd_stat_q <= is_stat;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        stat                 = '0;
        stat[STAT_RX_AVAIL]  = ~rx_empty;
        stat[STAT_TX_NFULL]  = ~tx_full;
        stat[STAT_OVERRUN]   = overrun_q;
        stat[STAT_FRAME_ERR] = frame_err_q;
        stat[STAT_TX_IDLE]   = tx_idle;
        stat[STAT_RX_IE]     = rx_ie_q;
        stat[STAT_TX_IE]     = tx_ie_q;
        stat[STAT_IRQ]       = irq_q;
        cpu_din              = 8'hFF;
        if (rd_lvl) cpu_din = is_stat ? stat : (rx_empty ? 8'hFF : rx_head);
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_exp_uart_port.sv
// Randomized self-checking bench for exp_uart_port against a queue-based behavioural model.
module tb_exp_uart_port;
    localparam int BAUD = 16;
    localparam logic [15:0] A_DATA = 16'hFBD0;
    localparam logic [15:0] A_STAT = 16'hFBD1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        iorq = 1'b0, rd = 1'b0, wr = 1'b0, m1 = 1'b0;
    logic [7:0]  cpu_din;
    logic        irq;
    logic        rxd = 1'b1;
    logic        txd;

    exp_uart_port #(.BAUD_DIV(BAUD), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .cpu_din(cpu_din), .irq(irq),
        .rxd(rxd), .txd(txd)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: RX contents, sticky flags, enables (transmitter assumed idle).
    logic [7:0] rx_q[$];
    bit         m_ov, m_fe, m_rx_ie, m_tx_ie;
    logic [8:0] tx_seen[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Passive line monitor: decodes every txd frame at mid-bit, stores {stop, byte}.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                repeat (BAUD / 2 - 1) @(negedge clk);
                if (txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BAUD) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (BAUD) @(negedge clk);
                    tx_seen.push_back({txd, b});
                end
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_dout = d; iorq = 1'b1; wr = 1'b1;
        repeat (2) @(negedge clk);
        iorq = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; iorq = 1'b1; rd = 1'b1;
        repeat (2) @(negedge clk);
        d = cpu_din;
        iorq = 1'b0; rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic ctrl_write(input logic [7:0] d);
        bus_write(A_STAT, d);
        m_rx_ie = d[0];
        m_tx_ie = d[1];
        if (d[7]) begin
            rx_q.delete();
            m_ov = 1'b0;
            m_fe = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = bits[i];
            repeat (BAUD - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        if (!stop) m_fe = 1'b1;
        else if (rx_q.size() < 16) rx_q.push_back(b);
        else m_ov = 1'b1;
    endtask

    function automatic logic [7:0] model_stat();
        bit avail, irq_m;
        avail = (rx_q.size() > 0);
        irq_m = (m_rx_ie && avail) || m_tx_ie;
        return {irq_m, m_tx_ie, m_rx_ie, 1'b1, m_fe, m_ov, 1'b1, avail};
    endfunction

    task automatic read_stat_check(input string tag, output logic [7:0] got);
        logic [7:0] exp;
        exp = model_stat();
        bus_read(A_STAT, got);
        check(tag, got, exp);
        m_ov = 1'b0;
        m_fe = 1'b0;
    endtask

    task automatic read_data_check(input string tag);
        logic [7:0] got, exp;
        bus_read(A_DATA, got);
        exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
        check(tag, got, exp);
    endtask

    initial begin : stimulus
        logic [7:0] got;
        logic [7:0] tx_bytes[20];
        logic [9:0] fr;
        logic       exp_bit;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_din", cpu_din, 8'hFF);
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);
        bus_read(A_STAT, got);
        check("rst_stat", got, 8'h12);
        read_data_check("rst_data_empty");

        // Exact TX waveform for &55: start edge two edges after the write event.
        fr = {1'b1, 8'h55, 1'b0};
        @(negedge clk);
        cpu_addr = A_DATA; cpu_dout = 8'h55; iorq = 1'b1; wr = 1'b1;
        for (int n = 1; n <= 162; n++) begin
            @(negedge clk);
            if (n == 2) begin iorq = 1'b0; wr = 1'b0; end
            exp_bit = (n < 3) ? 1'b1 : fr[(n - 3) / BAUD];
            check("tx55_wave", txd, exp_bit);
        end
        repeat (4) @(negedge clk);
        bus_read(A_STAT, got);
        check("tx55_idle_bit", got[4], 1'b1);
        check("tx55_stat", got, 8'h12);
        check("tx55_mon_cnt", tx_seen.size(), 1);
        if (tx_seen.size() > 0) check("tx55_mon", tx_seen[0], 9'h155);
        tx_seen.delete();

        // Burst of 20: the first goes straight to the shifter, 16 queue, the rest drop.
        for (int i = 0; i < 20; i++) begin
            tx_bytes[i] = 8'($urandom);
            bus_write(A_DATA, tx_bytes[i]);
        end
        bus_read(A_STAT, got);
        check("tx_full_stat", got, 8'h00);
        for (int c = 0; c < 6000; c++) begin
            if (tx_seen.size() >= 17) break;
            @(negedge clk);
        end
        repeat (200) @(negedge clk);
        check("tx_burst_cnt", tx_seen.size(), 17);
        for (int i = 0; i < 17 && i < tx_seen.size(); i++)
            check("tx_burst_byte", tx_seen[i], {1'b1, tx_bytes[i]});
        bus_read(A_STAT, got);
        check("tx_drained_stat", got, 8'h12);
        ctrl_write(8'h02);
        repeat (2) @(negedge clk);
        check("tx_ie_irq", irq, 1'b1);
        ctrl_write(8'h00);
        repeat (2) @(negedge clk);
        check("tx_ie_off_irq", irq, 1'b0);

        // Single RX byte with rx_ie.
        ctrl_write(8'h01);
        send_frame(8'hA7, 1'b1);
        check("rx_irq_rise", irq, 1'b1);
        bus_read(A_DATA, got);
        void'(rx_q.pop_front());
        check("rx_a7", got, 8'hA7);
        @(negedge clk);
        check("rx_irq_drop", irq, 1'b0);

        // 17 frames unread: the 17th overruns.
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1);
        read_stat_check("ovr_stat1", got);
        check("ovr_bit_set", got[2], 1'b1);
        read_stat_check("ovr_stat2", got);
        check("ovr_bit_clr", got[2], 1'b0);
        @(negedge clk);
        cpu_addr = A_DATA; iorq = 1'b1; m1 = 1'b1; rd = 1'b1;
        repeat (2) @(negedge clk);
        check("intack_din", cpu_din, 8'hFF);
        iorq = 1'b0; m1 = 1'b0; rd = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) read_data_check("ovr_data");

        // Framing error, then a one-clock glitch.
        send_frame(8'($urandom), 1'b0);
        read_stat_check("fe_stat", got);
        check("fe_bit", got[3], 1'b1);
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (40) @(negedge clk);
        read_stat_check("glitch_stat", got);
        read_data_check("glitch_data");

        // Random mix of line and bus activity.
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0: send_frame(8'($urandom), 1'b1);
                1: send_frame(8'($urandom), 1'b0);
                2: read_data_check("rand_data");
                3: read_stat_check("rand_stat", got);
                default: ctrl_write({($urandom_range(0, 3) == 0), 5'b0, 2'($urandom)});
            endcase
        end
        read_stat_check("rand_final_stat", got);
        for (int i = 0; i < 17; i++) read_data_check("rand_drain");

        // Reset in the middle of a TX frame and an RX frame.
        ctrl_write(8'h00);
        @(negedge clk); rxd = 1'b0;
        bus_write(A_DATA, 8'h00);
        repeat (60) @(negedge clk);
        check("mid_txd_low", txd, 1'b0);
        #1 reset = 1'b1;
        #1 check("rst_mid_txd", txd, 1'b1);
        rxd = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(A_STAT, got);
        check("rst_mid_stat", got, 8'h12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
